// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into aligned 32-bit memory
// accesses, with read-modify-write for sub-word stores and extended loads.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    input  logic [31:0]       mem_rd,
    output logic [2:0]        state_dbg
);

    // Handshake: a request transfers on a posedge where req_valid && req_ready;
    // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse
    // with no back-pressure.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state, state_nxt;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        lane_q;
    logic [15:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       merge_q;
    logic [31:0]       result_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;

    assign accept    = req_valid && (state == S_IDLE);
    assign req_err   = (req_size == 2'b11)
                    || (req_size == SZ_HALF && req_addr[0])
                    || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    assign mem_addr   = addr_q;
    assign mem_wd     = merge_q;
    assign resp_rdata = result_q;
    assign resp_err   = err_q;
    assign state_dbg  = state;

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                 state_nxt = S_RESP;
                    else if (!req_we)            state_nxt = S_LOAD;
                    else if (req_size == SZ_WORD) state_nxt = S_WRITE;
                    else                         state_nxt = S_READ;
                end
            end
            S_LOAD:  state_nxt = S_RESP;
            S_READ:  state_nxt = S_WRITE;
            S_WRITE: begin
                mem_we    = 1'b1;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Little-endian lane selection out of the fetched word.
    always_comb begin
        rd_byte = 8'h00;
        case (lane_q)
            2'd0: rd_byte = mem_rd[7:0];
            2'd1: rd_byte = mem_rd[15:8];
            2'd2: rd_byte = mem_rd[23:16];
            2'd3: rd_byte = mem_rd[31:24];
            default: rd_byte = 8'h00;
        endcase
        rd_half = lane_q[1] ? mem_rd[31:16] : mem_rd[15:0];

        load_val = mem_rd;
        if (size_q == SZ_BYTE)
            load_val = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
        else if (size_q == SZ_HALF)
            load_val = {{16{rd_half[15] & ~uns_q}}, rd_half};
    end

    always_comb begin
        merge_val = mem_rd;
        if (size_q == SZ_BYTE) begin
            case (lane_q)
                2'd0: merge_val[7:0]   = wdata_q[7:0];
                2'd1: merge_val[15:8]  = wdata_q[7:0];
                2'd2: merge_val[23:16] = wdata_q[7:0];
                2'd3: merge_val[31:24] = wdata_q[7:0];
                default: merge_val = mem_rd;
            endcase
        end else if (lane_q[1]) begin
            merge_val[31:16] = wdata_q;
        end else begin
            merge_val[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            lane_q   <= 2'b00;
            wdata_q  <= 16'h0000;
            addr_q   <= '0;
            merge_q  <= 32'h0;
            result_q <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                size_q   <= req_size;
                uns_q    <= req_unsigned;
                lane_q   <= req_addr[1:0];
                wdata_q  <= req_wdata[15:0];
                addr_q   <= {req_addr[ADDR_W-1:2], 2'b00};
                result_q <= 32'h0;
                err_q    <= req_err;
                if (req_we && req_size == SZ_WORD && !req_err)
                    merge_q <= req_wdata;
            end
            if (state == S_LOAD) result_q <= load_val;
            if (state == S_READ) merge_q  <= merge_val;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word memory model,
// with a response scoreboard and latency / write-pulse checks.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;
    logic [2:0]  state_dbg;

    logic [31:0] mem [0:63];
    logic        mem_init = 1'b1;

    logic [31:0] exp_q[$];
    logic        exp_err_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .state_dbg(state_dbg)
    );

    assign mem_rd = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
            mem[4] <= 32'h8899AABB;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One request: push the expected response, drive, then watch a fixed
    // window for responses and write pulses.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic hold, input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int exp_wr,
                          input logic [31:0] exp_wd, input logic [31:0] exp_wa);
        int lat, nresp, nwr;
        logic [31:0] wd_seen, wa_seen, e_rd;
        logic e_err;
        lat = 0; nresp = 0; nwr = 0; wd_seen = 32'h0; wa_seen = 32'h0;
        exp_q.push_back(exp_rd);
        exp_err_q.push_back(exp_err);
        @(negedge clk);
        chk({tag, "/ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (mem_we) begin
                nwr++; wd_seen = mem_wd; wa_seen = mem_addr;
            end
            if (resp_valid) begin
                nresp++;
                if (lat == 0) lat = i;
                req_valid = 1'b0;
                if (exp_q.size() > 0) begin
                    e_rd = exp_q.pop_front();
                    e_err = exp_err_q.pop_front();
                    chk({tag, "/rdata"}, resp_rdata, e_rd);
                    chk({tag, "/err"}, {31'h0, resp_err}, {31'h0, e_err});
                end
            end
        end
        req_valid = 1'b0;
        chk({tag, "/latency"}, lat, exp_lat);
        chk({tag, "/nresp"}, nresp, 1);
        chk({tag, "/nwrites"}, nwr, exp_wr);
        if (exp_wr > 0) begin
            chk({tag, "/wdata"}, wd_seen, exp_wd);
            chk({tag, "/waddr"}, wa_seen, exp_wa);
        end
    endtask

    initial begin
        int nwr, nresp;
        repeat (2) @(negedge clk);
        chk("rst/ready", {31'h0, req_ready}, 32'h1);
        chk("rst/resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst/resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst/resp_rdata", resp_rdata, 32'h0);
        chk("rst/mem_addr", mem_addr, 32'h0);
        chk("rst/mem_wd", mem_wd, 32'h0);
        chk("rst/mem_we", {31'h0, mem_we}, 32'h0);
        rst = 1'b0;
        mem_init = 1'b0;

        //      tag     we    size   uns   addr      wdata         hold  exp_rd        err  lat wr exp_wd        exp_wa
        do_req("lb",    1'b0, 2'b00, 1'b0, 32'h11, 32'h0,          1'b0, 32'hFFFFFFAA, 1'b0, 2, 0, 32'h0,        32'h0);
        do_req("lbu",   1'b0, 2'b00, 1'b1, 32'h11, 32'h0,          1'b0, 32'h000000AA, 1'b0, 2, 0, 32'h0,        32'h0);
        do_req("lh",    1'b0, 2'b01, 1'b0, 32'h12, 32'h0,          1'b0, 32'hFFFF8899, 1'b0, 2, 0, 32'h0,        32'h0);
        do_req("lw",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0,          1'b0, 32'h8899AABB, 1'b0, 2, 0, 32'h0,        32'h0);
        do_req("sh",    1'b1, 2'b01, 1'b0, 32'h12, 32'hDEAD1234,   1'b0, 32'h0,        1'b0, 3, 1, 32'h1234AABB, 32'h10);
        do_req("lw2",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,          1'b0, 32'h1234AABB, 1'b0, 2, 0, 32'h0,        32'h0);
        do_req("sb",    1'b1, 2'b00, 1'b0, 32'h13, 32'h00000077,   1'b0, 32'h0,        1'b0, 3, 1, 32'h7734AABB, 32'h10);
        do_req("lw3",   1'b0, 2'b10, 1'b1, 32'h10, 32'h0,          1'b0, 32'h7734AABB, 1'b0, 2, 0, 32'h0,        32'h0);
        do_req("sw",    1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D,   1'b0, 32'h0,        1'b0, 2, 1, 32'hCAFEF00D, 32'h20);
        do_req("lhu",   1'b0, 2'b01, 1'b1, 32'h10, 32'h0,          1'b0, 32'h0000AABB, 1'b0, 2, 0, 32'h0,        32'h0);
        do_req("lb0",   1'b0, 2'b00, 1'b0, 32'h10, 32'h0,          1'b0, 32'hFFFFFFBB, 1'b0, 2, 0, 32'h0,        32'h0);
        do_req("lb_sw", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0,          1'b0, 32'h0000000D, 1'b0, 2, 0, 32'h0,        32'h0);
        do_req("sb1",   1'b1, 2'b00, 1'b0, 32'h21, 32'h123456A5,   1'b0, 32'h0,        1'b0, 3, 1, 32'hCAFEA50D, 32'h20);
        do_req("e_lw",  1'b0, 2'b10, 1'b0, 32'h13, 32'h0,          1'b0, 32'h0,        1'b1, 1, 0, 32'h0,        32'h0);
        do_req("e_sh",  1'b1, 2'b01, 1'b0, 32'h11, 32'h0000BEEF,   1'b0, 32'h0,        1'b1, 1, 0, 32'h0,        32'h0);
        do_req("e_sz",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0,          1'b0, 32'h0,        1'b1, 1, 0, 32'h0,        32'h0);
        do_req("e_szw", 1'b1, 2'b11, 1'b0, 32'h10, 32'h11111111,   1'b0, 32'h0,        1'b1, 1, 0, 32'h0,        32'h0);
        chk("mem10_after_err", mem[4], 32'h7734AABB);
        chk("mem20_after_err", mem[8], 32'hCAFEA50D);

        // Reset while a byte store sits in READ: no write, no response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h13; req_wdata = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid/in_read", {29'h0, state_dbg}, 32'h2);
        rst = 1'b1;
        #1;
        chk("rstmid/mem_we", {31'h0, mem_we}, 32'h0);
        chk("rstmid/ready", {31'h0, req_ready}, 32'h1);
        chk("rstmid/resp_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        nwr = 0; nresp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_we) nwr++;
            if (resp_valid) nresp++;
        end
        chk("rstmid/nwrites", nwr, 0);
        chk("rstmid/nresp", nresp, 0);
        chk("rstmid/ready_after", {31'h0, req_ready}, 32'h1);
        chk("rstmid/mem_unchanged", mem[4], 32'h7734AABB);

        // Held req_valid through LOAD/RESP must yield a single response.
        do_req("hold",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0,          1'b1, 32'hCAFEA50D, 1'b0, 2, 0, 32'h0,        32'h0);

        chk("sb_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
